csi_packet_controller: RTL and testbench
========================================

Name: csi_packet_controller

Overview:
- Sequences the D-PHY receive datapath: consumes the 32-bit word stream from the word combiner, decodes the CSI-2 packet header, counts payload words and ends each packet.
- Drives the combiner's `wait_for_sync` and `packet_done` inputs; the combiner forwards `packet_done` to the byte aligners so they re-hunt for sync.
- Presents decoded header fields and a framed payload stream to the downstream unpacker.

Parameters:
- TIMEOUT, 1023: max enabled cycles without `word_enable` while in PAYLOAD before abort; 1 to 65535.

Ports:
- clock  in  1  byte clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  active-high clock enable; when low, all registers hold
- word_in  in  32  combiner word; byte0 = [7:0]
- word_enable  in  1  `word_in` valid this cycle
- word_frame  in  1  combiner in-packet flag
- wait_for_sync  out  1  to combiner: ready for next packet
- packet_done  out  1  to combiner: one-cycle end-of-packet pulse
- vc  out  2  virtual channel, DataID[7:6]
- data_type  out  6  DataID[5:0]
- word_count  out  16  header bytes 1 (LSB) and 2 (MSB)
- header_valid  out  1  one-cycle pulse: header fields updated
- long_packet  out  1  `data_type` >= 6'h10, valid with `header_valid`
- payload_data  out  32  payload word
- payload_enable  out  1  `payload_data` valid
- payload_last  out  1  final payload word (contains CRC bytes)
- abort  out  1  one-cycle pulse: packet terminated abnormally

Behaviour:
- Reset (async, any state): state=SYNC; `wait_for_sync`=1; all other outputs 0; remaining-word counter 0; timeout counter 0.
- Outputs are registered. Pulses last one enabled cycle. With `enable` low, a pending pulse holds and is presented for exactly one enabled cycle.
- SYNC:
  - `wait_for_sync`=1.
  - On `word_frame` & `word_enable`, latch `vc`, `data_type`, `word_count` from `word_in[7:0]`, `[23:8]`. ECC byte [31:24] is ignored.
  - Pulse `header_valid`; drive `wait_for_sync`=0 from the next edge.
- Short packet (`data_type` < 6'h10):
  - `packet_done`=1 on the same edge as `header_valid`; return to SYNC.
  - `wait_for_sync`=1 from the following cycle.
- Long packet:
  - Load remaining = (`word_count` + 5) >> 2, computed at 17 bits with no overflow. For `word_count`=0 the result is 1: the CRC-only word.
  - Go to PAYLOAD.
- PAYLOAD:
  - Each `word_enable`: `payload_data` <= `word_in`, `payload_enable`=1, remaining decrements, timeout counter clears.
  - When remaining==1 at that word: `payload_last`=1 and `packet_done`=1 on the same edge; return to SYNC.
- Latency: header or payload word in → corresponding output one cycle later.
- Abort from PAYLOAD:
  - Triggers: `word_frame` low with no `word_enable`, or timeout counter reaching TIMEOUT.
  - Response: `abort`=1, `packet_done`=1, no `payload_last`, go to SYNC.
- Simultaneous events:
  - `word_frame` low together with `word_enable`: the word is processed first; abort applies only if it was not the last word.
  - Timeout and a word in the same cycle: the word wins and the counter clears.
- Extra `word_enable` after `packet_done` while `word_frame` is still high is ignored until SYNC sees a new frame. SYNC requires `word_frame` to have been low at least one enabled cycle since the last packet.
- `word_enable` without `word_frame` in SYNC: ignored.
- Reset mid-packet: immediate return to SYNC; no `packet_done` issued.

Test Plan:
- Short packet: header 32'hXX00_0000 | DT 6'h00, VC 1 → `header_valid`, `vc`=1, `long_packet`=0, `packet_done` same cycle, no `payload_enable`, `wait_for_sync` back to 1 the cycle after.
- Long packet, DT 6'h2B, `word_count`=10 → 3 payload words; `payload_last` and `packet_done` on the 3rd; `abort`=0.
- `word_count`=0 long packet → exactly 1 payload word with `payload_last`; `word_count`=16'hFFFF → 16385 words, verifying no counter overflow.
- TIMEOUT=8, stall after 1 payload word → `abort` and `packet_done` exactly 8 enabled cycles later; next frame header decoded normally.
- `word_frame` drops mid-payload → `abort`+`packet_done`, no `payload_last`. Toggle `enable` low during a pending `packet_done` → pulse seen for exactly 1 enabled cycle.
- Assert `reset` mid-payload (async, between edges) → outputs 0 and `wait_for_sync`=1 immediately; the next packet decodes correctly.

Source files
------------

// File: rtl/csi_packet_controller.sv
// rtl/csi_packet_controller.sv - CSI-2 packet header decode, payload framing and packet termination
module csi_packet_controller #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] word_in,
    input  logic        word_enable,
    input  logic        word_frame,
    output logic        wait_for_sync,
    output logic        packet_done,
    output logic [1:0]  vc,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        header_valid,
    output logic        long_packet,
    output logic [31:0] payload_data,
    output logic        payload_enable,
    output logic        payload_last,
    output logic        abort
);

    typedef enum logic {
        ST_SYNC    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    // Set once word_frame has been seen low; a new header is only taken when set,
    // so trailing words of a finished packet are never mistaken for a header.
    logic        armed_q, armed_d;
    // Words still expected, including the word carrying the CRC bytes.
    logic [16:0] remaining_q, remaining_d;
    logic [15:0] timeout_q, timeout_d;

    logic        wait_for_sync_q, wait_for_sync_d;
    logic        packet_done_q, packet_done_d;
    logic [1:0]  vc_q, vc_d;
    logic [5:0]  data_type_q, data_type_d;
    logic [15:0] word_count_q, word_count_d;
    logic        header_valid_q, header_valid_d;
    logic        long_packet_q, long_packet_d;
    logic [31:0] payload_data_q, payload_data_d;
    logic        payload_enable_q, payload_enable_d;
    logic        payload_last_q, payload_last_d;
    logic        abort_q, abort_d;

    // Next-state and registered-output computation for the SYNC/PAYLOAD sequencer.
    always_comb begin
        state_d          = state_q;
        armed_d          = armed_q | ~word_frame;
        remaining_d      = remaining_q;
        timeout_d        = timeout_q;
        wait_for_sync_d  = wait_for_sync_q;
        vc_d             = vc_q;
        data_type_d      = data_type_q;
        word_count_d     = word_count_q;
        long_packet_d    = long_packet_q;
        payload_data_d   = payload_data_q;
        header_valid_d   = 1'b0;
        packet_done_d    = 1'b0;
        payload_enable_d = 1'b0;
        payload_last_d   = 1'b0;
        abort_d          = 1'b0;

        case (state_q)
            ST_SYNC: begin
                wait_for_sync_d = 1'b1;
                timeout_d       = 16'd0;
                if (word_frame && word_enable && armed_q) begin
                    vc_d            = word_in[7:6];
                    data_type_d     = word_in[5:0];
                    word_count_d    = word_in[23:8];
                    long_packet_d   = (word_in[5:0] >= 6'h10);
                    header_valid_d  = 1'b1;
                    wait_for_sync_d = 1'b0;
                    armed_d         = 1'b0;
                    if (word_in[5:0] >= 6'h10) begin
                        // Payload bytes plus two CRC bytes, rounded up to whole words.
                        remaining_d = ({1'b0, word_in[23:8]} + 17'd5) >> 2;
                        state_d     = ST_PAYLOAD;
                    end else begin
                        packet_done_d = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                wait_for_sync_d = 1'b0;
                if (word_enable) begin
                    payload_data_d   = word_in;
                    payload_enable_d = 1'b1;
                    remaining_d      = remaining_q - 17'd1;
                    timeout_d        = 16'd0;
                    if (remaining_q == 17'd1) begin
                        payload_last_d = 1'b1;
                        packet_done_d  = 1'b1;
                        state_d        = ST_SYNC;
                    end else if (!word_frame) begin
                        // Frame closed before the last word arrived.
                        abort_d       = 1'b1;
                        packet_done_d = 1'b1;
                        remaining_d   = 17'd0;
                        state_d       = ST_SYNC;
                    end
                end else if (!word_frame || (timeout_q == TIMEOUT_LAST)) begin
                    abort_d       = 1'b1;
                    packet_done_d = 1'b1;
                    remaining_d   = 17'd0;
                    timeout_d     = 16'd0;
                    state_d       = ST_SYNC;
                end else begin
                    timeout_d = timeout_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State and output registers; everything holds while enable is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_SYNC;
            armed_q          <= 1'b0;
            remaining_q      <= 17'd0;
            timeout_q        <= 16'd0;
            wait_for_sync_q  <= 1'b1;
            packet_done_q    <= 1'b0;
            vc_q             <= 2'd0;
            data_type_q      <= 6'd0;
            word_count_q     <= 16'd0;
            header_valid_q   <= 1'b0;
            long_packet_q    <= 1'b0;
            payload_data_q   <= 32'd0;
            payload_enable_q <= 1'b0;
            payload_last_q   <= 1'b0;
            abort_q          <= 1'b0;
        end else if (enable) begin
            state_q          <= state_d;
            armed_q          <= armed_d;
            remaining_q      <= remaining_d;
            timeout_q        <= timeout_d;
            wait_for_sync_q  <= wait_for_sync_d;
            packet_done_q    <= packet_done_d;
            vc_q             <= vc_d;
            data_type_q      <= data_type_d;
            word_count_q     <= word_count_d;
            header_valid_q   <= header_valid_d;
            long_packet_q    <= long_packet_d;
            payload_data_q   <= payload_data_d;
            payload_enable_q <= payload_enable_d;
            payload_last_q   <= payload_last_d;
            abort_q          <= abort_d;
        end
    end

    assign wait_for_sync  = wait_for_sync_q;
    assign packet_done    = packet_done_q;
    assign vc             = vc_q;
    assign data_type      = data_type_q;
    assign word_count     = word_count_q;
    assign header_valid   = header_valid_q;
    assign long_packet    = long_packet_q;
    assign payload_data   = payload_data_q;
    assign payload_enable = payload_enable_q;
    assign payload_last   = payload_last_q;
    assign abort          = abort_q;

endmodule

// File: tb/tb_csi_packet_controller.sv
// tb/tb_csi_packet_controller.sv - directed self-checking bench for csi_packet_controller
`timescale 1ns/1ps
module tb_csi_packet_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] word_in;
    logic        word_enable;
    logic        word_frame;
    logic        wait_for_sync;
    logic        packet_done;
    logic [1:0]  vc;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic        header_valid;
    logic        long_packet;
    logic [31:0] payload_data;
    logic        payload_enable;
    logic        payload_last;
    logic        abort;

    int n_checks = 0;
    int n_fail   = 0;

    csi_packet_controller #(.TIMEOUT(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .word_in        (word_in),
        .word_enable    (word_enable),
        .word_frame     (word_frame),
        .wait_for_sync  (wait_for_sync),
        .packet_done    (packet_done),
        .vc             (vc),
        .data_type      (data_type),
        .word_count     (word_count),
        .header_valid   (header_valid),
        .long_packet    (long_packet),
        .payload_data   (payload_data),
        .payload_enable (payload_enable),
        .payload_last   (payload_last),
        .abort          (abort)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic f, input logic we, input logic [31:0] w);
        word_frame  = f;
        word_enable = we;
        word_in     = w;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'd0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        n_checks++; if (wait_for_sync !== 1'b1) begin n_fail++; $display("FAIL reset_wfs: got %b want 1", wait_for_sync); end
        n_checks++; if ({packet_done, header_valid, payload_enable, payload_last, abort, long_packet} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 000000", {packet_done, header_valid, payload_enable, payload_last, abort, long_packet}); end
        n_checks++; if ({vc, data_type, word_count, payload_data} !== 56'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {vc, data_type, word_count, payload_data}); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_short();
        drive(1'b0, 1'b1, 32'h0000_0050);
        tick();
        n_checks++; if (header_valid !== 1'b0) begin n_fail++; $display("FAIL stray_word_hv: got %b want 0", header_valid); end
        drive(1'b1, 1'b1, 32'hAA00_0040);
        tick();
        n_checks++; if (header_valid !== 1'b1) begin n_fail++; $display("FAIL short_hv: got %b want 1", header_valid); end
        n_checks++; if (vc !== 2'd1 || data_type !== 6'h00) begin n_fail++; $display("FAIL short_id: got vc=%0d dt=%h want vc=1 dt=00", vc, data_type); end
        n_checks++; if (long_packet !== 1'b0) begin n_fail++; $display("FAIL short_long: got %b want 0", long_packet); end
        n_checks++; if (packet_done !== 1'b1 || payload_enable !== 1'b0) begin n_fail++; $display("FAIL short_done: got done=%b pe=%b want 1 0", packet_done, payload_enable); end
        n_checks++; if (wait_for_sync !== 1'b0) begin n_fail++; $display("FAIL short_wfs0: got %b want 0", wait_for_sync); end
        drive(1'b0, 1'b0, 32'd0);
        tick();
        n_checks++; if (wait_for_sync !== 1'b1 || packet_done !== 1'b0 || header_valid !== 1'b0) begin n_fail++; $display("FAIL short_after: got wfs=%b done=%b hv=%b want 1 0 0", wait_for_sync, packet_done, header_valid); end
        idle(1);
    endtask

    task automatic test_long();
        drive(1'b1, 1'b1, 32'h1200_0A2B);
        tick();
        n_checks++; if (header_valid !== 1'b1 || long_packet !== 1'b1 || word_count !== 16'd10 || data_type !== 6'h2B || vc !== 2'd0) begin n_fail++; $display("FAIL long_hdr: got hv=%b lp=%b wc=%0d dt=%h vc=%0d want 1 1 10 2b 0", header_valid, long_packet, word_count, data_type, vc); end
        n_checks++; if (packet_done !== 1'b0) begin n_fail++; $display("FAIL long_hdr_done: got %b want 0", packet_done); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'hC0DE_0000 + i);
            tick();
            n_checks++; if (payload_enable !== 1'b1 || payload_data !== 32'hC0DE_0000 + i) begin n_fail++; $display("FAIL long_word%0d: got pe=%b data=%h want 1 %h", i, payload_enable, payload_data, 32'hC0DE_0000 + i); end
            n_checks++; if (payload_last !== (i == 2) || packet_done !== (i == 2) || abort !== 1'b0) begin n_fail++; $display("FAIL long_end%0d: got last=%b done=%b abort=%b want %b %b 0", i, payload_last, packet_done, abort, i == 2, i == 2); end
        end
        drive(1'b1, 1'b1, 32'h0000_0A2B);
        tick();
        n_checks++; if (payload_enable !== 1'b0 || header_valid !== 1'b0) begin n_fail++; $display("FAIL long_extra_ignored: got pe=%b hv=%b want 0 0", payload_enable, header_valid); end
        idle(2);
    endtask

    task automatic test_wc_zero();
        drive(1'b1, 1'b1, 32'h0000_0012);
        tick();
        n_checks++; if (header_valid !== 1'b1 || long_packet !== 1'b1 || word_count !== 16'd0) begin n_fail++; $display("FAIL wc0_hdr: got hv=%b lp=%b wc=%0d want 1 1 0", header_valid, long_packet, word_count); end
        drive(1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        n_checks++; if (payload_enable !== 1'b1 || payload_last !== 1'b1 || packet_done !== 1'b1 || payload_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wc0_word: got pe=%b last=%b done=%b data=%h want 1 1 1 deadbeef", payload_enable, payload_last, packet_done, payload_data); end
        idle(1);
        n_checks++; if (payload_enable !== 1'b0) begin n_fail++; $display("FAIL wc0_single: got pe=%b want 0", payload_enable); end
        idle(1);
    endtask

    task automatic test_wc_max();
        int errs = 0;
        drive(1'b1, 1'b1, 32'h00FF_FF6B);
        tick();
        n_checks++; if (header_valid !== 1'b1 || word_count !== 16'hFFFF || vc !== 2'd1 || data_type !== 6'h2B) begin n_fail++; $display("FAIL wcmax_hdr: got hv=%b wc=%h vc=%0d dt=%h want 1 ffff 1 2b", header_valid, word_count, vc, data_type); end
        for (int i = 0; i < 16385; i++) begin
            drive(1'b1, 1'b1, i);
            tick();
            if (payload_enable !== 1'b1 || payload_data !== i || payload_last !== (i == 16384) || packet_done !== (i == 16384) || abort !== 1'b0) errs++;
        end
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL wcmax_words: got %0d bad words want 0", errs); end
        drive(1'b1, 1'b1, 32'h5555_5555);
        tick();
        n_checks++; if (payload_enable !== 1'b0) begin n_fail++; $display("FAIL wcmax_count: got pe=%b after 16385 words want 0", payload_enable); end
        idle(2);
    endtask

    task automatic test_timeout();
        int k = 0;
        drive(1'b1, 1'b1, 32'h0000_642B);
        tick();
        drive(1'b1, 1'b1, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b0, 32'd0);
        while (k < 20) begin
            tick();
            k++;
            if (abort === 1'b1) break;
        end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 8", k); end
        n_checks++; if (packet_done !== 1'b1 || payload_last !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got done=%b last=%b want 1 0", packet_done, payload_last); end
        idle(1);
        drive(1'b1, 1'b1, 32'h0000_00C1);
        tick();
        n_checks++; if (header_valid !== 1'b1 || vc !== 2'd3 || data_type !== 6'h01 || packet_done !== 1'b1) begin n_fail++; $display("FAIL timeout_next_hdr: got hv=%b vc=%0d dt=%h done=%b want 1 3 01 1", header_valid, vc, data_type, packet_done); end
        idle(2);
    endtask

    task automatic test_frame_drop();
        drive(1'b1, 1'b1, 32'h0000_142B);
        tick();
        drive(1'b1, 1'b1, 32'hAAAA_0001);
        tick();
        drive(1'b1, 1'b1, 32'hAAAA_0002);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        n_checks++; if (abort !== 1'b1 || packet_done !== 1'b1 || payload_last !== 1'b0) begin n_fail++; $display("FAIL drop_abort: got abort=%b done=%b last=%b want 1 1 0", abort, packet_done, payload_last); end
        enable = 1'b0;
        repeat (3) tick();
        n_checks++; if (packet_done !== 1'b1 || abort !== 1'b1) begin n_fail++; $display("FAIL drop_hold: got done=%b abort=%b want 1 1", packet_done, abort); end
        enable = 1'b1;
        tick();
        n_checks++; if (packet_done !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got done=%b abort=%b want 0 0", packet_done, abort); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h0000_282B);
        tick();
        drive(1'b1, 1'b1, 32'hBBBB_0001);
        tick();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (wait_for_sync !== 1'b1 || payload_enable !== 1'b0 || packet_done !== 1'b0 || word_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid: got wfs=%b pe=%b done=%b wc=%0d want 1 0 0 0", wait_for_sync, payload_enable, packet_done, word_count); end
        tick();
        reset = 1'b0;
        idle(2);
        drive(1'b1, 1'b1, 32'h0000_0822);
        tick();
        n_checks++; if (header_valid !== 1'b1 || long_packet !== 1'b1 || word_count !== 16'd8 || data_type !== 6'h22) begin n_fail++; $display("FAIL rst_next_hdr: got hv=%b lp=%b wc=%0d dt=%h want 1 1 8 22", header_valid, long_packet, word_count, data_type); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'hE000_0000 + i);
            tick();
            n_checks++; if (payload_enable !== 1'b1 || payload_last !== (i == 2)) begin n_fail++; $display("FAIL rst_next_word%0d: got pe=%b last=%b want 1 %b", i, payload_enable, payload_last, i == 2); end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_wc_zero();
        test_wc_max();
        test_timeout();
        test_frame_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
